// File: rtl/instr_register_arbiter_if.sv
// Requester / instruction-register bundle for instr_register_arbiter.
// slave = arbiter side, master = requesters + register/consumer side.
interface instr_register_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][3:0]   req_opcode;
  logic [NUM_REQ-1:0][31:0]  req_operand_a;
  logic [NUM_REQ-1:0][31:0]  req_operand_b;
  logic                      free_valid;
  logic [ADDR_W-1:0]         free_addr;
  logic                      reg_reset_n;
  logic                      load_en;
  logic [3:0]                opcode;
  logic [31:0]               operand_a;
  logic [31:0]               operand_b;
  logic [ADDR_W-1:0]         write_pointer;
  logic [GW-1:0]             grant_id;
  logic [ADDR_W:0]           count;
  logic                      full;
  logic                      err_free;

  modport master (
    output req_valid, req_opcode, req_operand_a, req_operand_b, free_valid, free_addr,
    input  req_ready, reg_reset_n, load_en, opcode, operand_a, operand_b,
           write_pointer, grant_id, count, full, err_free
  );

  modport slave (
    input  req_valid, req_opcode, req_operand_a, req_operand_b, free_valid, free_addr,
    output req_ready, reg_reset_n, load_en, opcode, operand_a, operand_b,
           write_pointer, grant_id, count, full, err_free
  );
endinterface

// File: rtl/instr_register_arbiter.sv
// Round-robin arbiter sharing the instruction-register write port; allocates
// the lowest free slot per accepted instruction and tracks occupancy in a bitmap.
module instr_register_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  instr_register_arbiter_if.slave      bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [DEPTH-1:0]   bitmap_q, bitmap_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0]  wp_q, wp_d;
  logic [3:0]         opcode_q, opcode_d;
  logic [31:0]        opa_q, opa_d, opb_q, opb_d;
  logic               load_en_q, load_en_d;
  logic               err_free_q, err_free_d;
  logic               reg_reset_n_q;

  logic               full;
  logic               found, accept, free_ok;
  logic [GW-1:0]      win;
  logic [GW:0]        idx;
  logic [ADDR_W-1:0]  slot;
  logic [NUM_REQ-1:0] ready;

  assign full = (count_q == (ADDR_W+1)'(DEPTH));

  // Rotating priority: first valid requester at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  assign accept = found && !reset && !full;

  always_comb begin
    ready      = '0;
    ready[win] = accept;
  end
  assign bus.req_ready = ready;

  // Lowest clear bit of the pre-edge bitmap; only meaningful when not full.
  always_comb begin
    slot = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!bitmap_q[i]) slot = ADDR_W'(i);
  end

  assign free_ok = bus.free_valid && bitmap_q[bus.free_addr];

  always_comb begin
    bitmap_d   = bitmap_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    wp_d       = wp_q;
    opcode_d   = opcode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    load_en_d  = accept;
    err_free_d = bus.free_valid && !bitmap_q[bus.free_addr];
    if (accept) begin
      bitmap_d[slot] = 1'b1;
      wp_d           = slot;
      grant_id_d     = win;
      rr_ptr_d       = (win == GW'(NUM_REQ-1)) ? '0 : win + 1'b1;
      opcode_d       = bus.req_opcode[win];
      opa_d          = bus.req_operand_a[win];
      opb_d          = bus.req_operand_b[win];
    end
    // A slot allocated this edge was clear pre-edge, so it can never be the freed one.
    if (free_ok) bitmap_d[bus.free_addr] = 1'b0;
    count_d = count_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(free_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap_q      <= '0;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      count_q       <= '0;
      wp_q          <= '0;
      opcode_q      <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      load_en_q     <= 1'b0;
      err_free_q    <= 1'b0;
      reg_reset_n_q <= 1'b0;
    end else begin
      bitmap_q      <= bitmap_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      count_q       <= count_d;
      wp_q          <= wp_d;
      opcode_q      <= opcode_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      load_en_q     <= load_en_d;
      err_free_q    <= err_free_d;
      reg_reset_n_q <= 1'b1;
    end
  end

  assign bus.reg_reset_n   = reg_reset_n_q;
  assign bus.load_en       = load_en_q;
  assign bus.opcode        = opcode_q;
  assign bus.operand_a     = opa_q;
  assign bus.operand_b     = opb_q;
  assign bus.write_pointer = wp_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.count         = count_q;
  assign bus.full          = full;
  assign bus.err_free      = err_free_q;
endmodule

// File: tb/tb_instr_register_arbiter.sv
// Directed bench for instr_register_arbiter: expected loads are queued when a
// grant is seen and compared when load_en appears one cycle later.
module tb_instr_register_arbiter;
  localparam int NR = 4, DP = 32, AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_register_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus();
  instr_register_arbiter #(.NUM_REQ(NR), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    logic [3:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [AW-1:0] wp;
    logic [1:0]    gid;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0]  op_of(input int i); return 4'(i + 8); endfunction
  function automatic logic [31:0] a_of(input int i);  return 32'(-(i * 11 + 1)); endfunction
  function automatic logic [31:0] b_of(input int i);  return 32'(32'h1000 + i); endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.req_valid  = '0;
    bus.free_valid = 1'b0;
  endtask

  task automatic all_req;
    for (int i = 0; i < NR; i++) begin
      bus.req_opcode[2'(i)]    = op_of(i);
      bus.req_operand_a[2'(i)] = a_of(i);
      bus.req_operand_b[2'(i)] = b_of(i);
    end
    bus.req_valid = '1;
  endtask

  task automatic push(input int i, input int wp);
    exp_t e;
    e.op = op_of(i); e.a = a_of(i); e.b = b_of(i); e.wp = AW'(wp); e.gid = 2'(i);
    sb.push_back(e);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (bus.load_en === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ld_opcode", bus.opcode, e.op);
        chk("ld_operand_a", bus.operand_a, e.a);
        chk("ld_operand_b", bus.operand_b, e.b);
        chk("ld_write_pointer", bus.write_pointer, e.wp);
        chk("ld_grant_id", bus.grant_id, e.gid);
      end
    end
  end

  initial begin
    bus.free_valid = 1'b0;
    bus.free_addr  = '0;
    all_req();

    // T1: reset held two cycles with every requester valid
    @(negedge clk);
    chk("t1_ready", bus.req_ready, 0);
    chk("t1_load_en", bus.load_en, 0);
    chk("t1_count", bus.count, 0);
    chk("t1_reg_reset_n", bus.reg_reset_n, 0);
    chk("t1_full", bus.full, 0);
    cyc();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("t1_reg_reset_n_low", bus.reg_reset_n, 0);
    cyc();
    @(negedge clk);
    chk("t1_reg_reset_n_rel", bus.reg_reset_n, 1);

    // T2: single request from requester 1
    cyc();
    bus.req_opcode[1] = 4'd3;
    bus.req_operand_a[1] = 32'(-5);
    bus.req_operand_b[1] = 32'd7;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("t2_ready", bus.req_ready, 4'b0010);
    begin
      exp_t e;
      e.op = 4'd3; e.a = 32'(-5); e.b = 32'd7; e.wp = '0; e.gid = 2'd1;
      sb.push_back(e);
    end
    cyc();
    idle();
    @(negedge clk);
    chk("t2_load_en", bus.load_en, 1);
    chk("t2_count", bus.count, 1);

    // T3: round-robin with all four valid for eight cycles
    do_reset();
    all_req();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_ready", bus.req_ready, 64'(1) << (k % NR));
      push(k % NR, k);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t3_count", bus.count, 8);
    chk("t3_load_en", bus.load_en, 1);

    // T4: fill all 32 slots, then free slot 5 and reuse it
    do_reset();
    all_req();
    for (int k = 0; k < DP; k++) begin
      @(negedge clk);
      chk("t4_ready", bus.req_ready, 64'(1) << (k % NR));
      push(k % NR, k);
      cyc();
    end
    @(negedge clk);
    chk("t4_full", bus.full, 1);
    chk("t4_ready_full", bus.req_ready, 0);
    chk("t4_count", bus.count, DP);
    cyc();
    @(negedge clk);
    chk("t4_load_en_full", bus.load_en, 0);
    cyc();
    bus.free_valid = 1'b1;
    bus.free_addr  = AW'(5);
    @(negedge clk);
    chk("t4_ready_freeing", bus.req_ready, 0);
    cyc();
    bus.free_valid = 1'b0;
    @(negedge clk);
    chk("t4_full_after_free", bus.full, 0);
    chk("t4_count_after_free", bus.count, DP - 1);
    chk("t4_ready_after_free", bus.req_ready, 4'b0001);
    push(0, 5);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_count_refill", bus.count, DP);
    chk("t4_full_refill", bus.full, 1);

    // T5: free slot 3 and request from 2 in the same cycle while full
    cyc();
    bus.free_valid = 1'b1;
    bus.free_addr  = AW'(3);
    bus.req_valid  = 4'b0100;
    @(negedge clk);
    chk("t5_no_grant", bus.req_ready, 0);
    cyc();
    bus.free_valid = 1'b0;
    @(negedge clk);
    chk("t5_grant", bus.req_ready, 4'b0100);
    push(2, 3);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_count", bus.count, DP);

    // T6a: free slot 10 legitimately, then again while it is unoccupied
    cyc();
    bus.free_valid = 1'b1;
    bus.free_addr  = AW'(10);
    @(negedge clk);
    chk("t6_err_idle", bus.err_free, 0);
    cyc();
    @(negedge clk);
    chk("t6_count_first", bus.count, DP - 1);
    chk("t6_err_first", bus.err_free, 0);
    cyc();
    bus.free_valid = 1'b0;
    @(negedge clk);
    chk("t6_err_pulse", bus.err_free, 1);
    chk("t6_count_unch", bus.count, DP - 1);
    cyc();
    @(negedge clk);
    chk("t6_err_clear", bus.err_free, 0);

    // T6b: reset asserted in the middle of a burst
    do_reset();
    all_req();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push(k, k);
      cyc();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ready_in_reset", bus.req_ready, 0);
    chk("t6_load_before_rst", bus.load_en, 1);
    cyc();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("t6_load_after_rst", bus.load_en, 0);
    chk("t6_count_after_rst", bus.count, 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
